// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the register-side holding write and the UART transmitter.
//   Params : DEPTH_LOG2 (log2 entries, 2..8), WIDTH (data bits)
//   Inputs : clk, reset_n (async, active-low), wdata, we, fifo_read_tx (active-low pop),
//            flush (sync clear), clr_overflow
//   Outputs: tx_dout_reg (registered head), fifo_empty, fifo_full, fifo_count, overflow
//   Macro  : UART_TX_FIFO_OVERFLOW_EN enables the sticky overflow flag; otherwise it is tied low.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  we,
    input  logic                  fifo_read_tx,
    input  logic                  flush,
    input  logic                  clr_overflow,
    output logic [WIDTH-1:0]      tx_dout_reg,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  rd_ok, wr_ok;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_count = count;
    // A read frees the slot the same-cycle write lands in, so full + read + write is accepted.
    assign rd_ok = !fifo_read_tx && !fifo_empty;
    assign wr_ok = we && (!fifo_full || rd_ok);

    always_ff @(posedge clk)
        if (wr_ok && !flush)
            mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_dout_reg <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr      <= rd_ptr + 1'b1;
                tx_dout_reg <= mem[rd_ptr];
            end
            count <= (wr_ok && !rd_ok) ? count + 1'b1 :
                     (rd_ok && !wr_ok) ? count - 1'b1 : count;
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    // Set wins over clear; flush leaves the flag untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (!flush)
            overflow <= (we && !wr_ok) ? 1'b1 : clr_overflow ? 1'b0 : overflow;
    end
`else
    logic unused_clr_overflow;
    assign unused_clr_overflow = clr_overflow;
    assign overflow = 1'b0;
`endif
endmodule
